// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions: fetch FSM encodings and the default halt word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
    localparam int          WORD_BYTES         = 4;

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory: one write port, one registered read port with read enable.
// Contents survive reset; only the read register is cleared.
module fetch_imem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = mem[i_raddr];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: byte loader into instruction memory, PC sequencing with redirects,
// stall hold and halt detection.
//
//   state   | meaning
//   IDLE    | after reset, waiting for load or run
//   LOAD    | accepting loader bytes, MSB-first, four per word
//   RUN     | fetching one word per cycle from PC
//   HALT    | halt word seen on a valid output; PC and outputs frozen
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   PC_SIZE     = 32,
    parameter int                   INST_SIZE   = 32,
    parameter int                   BYTE_SIZE   = 8,
    parameter int                   IMEM_ADDR_W = 8,
    parameter logic [INST_SIZE-1:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_load_start,
    input  logic                   i_load_valid,
    input  logic [BYTE_SIZE-1:0]   i_load_byte,
    input  logic                   i_run,
    input  logic                   i_stall,
    input  logic                   i_branch,
    input  logic                   i_jal,
    input  logic                   i_jalr,
    input  logic [PC_SIZE-1:0]     i_branch_addr,
    input  logic [PC_SIZE-1:0]     i_jump_addr,
    input  logic [PC_SIZE-1:0]     i_last_reg,
    output logic [PC_SIZE-1:0]     o_pc,
    output logic [PC_SIZE-1:0]     o_next_pc,
    output logic [INST_SIZE-1:0]   o_instr,
    output logic                   o_valid,
    output logic                   o_halt,
    output logic [IMEM_ADDR_W:0]   o_load_count,
    output logic [1:0]             o_state
);

    localparam logic [PC_SIZE-1:0]   PC_STEP   = PC_SIZE'(4);
    localparam logic [IMEM_ADDR_W:0] CNT_ONE   = (IMEM_ADDR_W+1)'(1);
    localparam logic [1:0]           LAST_BYTE = 2'(WORD_BYTES - 1);

    fetch_state_e                     state_d, state_q;
    logic [PC_SIZE-1:0]               pc_d, pc_q;
    logic [PC_SIZE-1:0]               out_pc_d, out_pc_q;
    logic [PC_SIZE-1:0]               out_npc_d, out_npc_q;
    logic                             valid_d, valid_q;
    logic [IMEM_ADDR_W:0]             load_cnt_d, load_cnt_q;
    logic [1:0]                       byte_cnt_d, byte_cnt_q;
    logic [INST_SIZE-BYTE_SIZE-1:0]   shift_d, shift_q;

    logic                             imem_we;
    logic                             imem_re;
    logic [INST_SIZE-1:0]             imem_rdata;
    logic                             redirect;
    logic [PC_SIZE-1:0]               redirect_pc;
    logic                             halt_hit;

    assign redirect = i_jalr | i_jal | i_branch;
    assign halt_hit = valid_q && (imem_rdata == HALT_INSTR);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_npc_d   = out_npc_q;
        valid_d     = valid_q;
        load_cnt_d  = load_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        imem_we     = 1'b0;
        imem_re     = 1'b0;

        if (i_jalr) begin
            redirect_pc = i_last_reg;
        end else if (i_jal) begin
            redirect_pc = i_jump_addr;
        end else begin
            redirect_pc = i_branch_addr;
        end

        if (i_load_start) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            byte_cnt_d = '0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (i_run) begin
                        state_d    = ST_RUN;
                        pc_d       = '0;
                        byte_cnt_d = '0;
                        valid_d    = 1'b0;
                    end else if (state_q == ST_LOAD && i_load_valid && !load_cnt_q[IMEM_ADDR_W]) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            imem_we    = 1'b1;
                            load_cnt_d = load_cnt_q + CNT_ONE;
                            byte_cnt_d = '0;
                        end else begin
                            shift_d    = {shift_q[INST_SIZE-2*BYTE_SIZE-1:0], i_load_byte};
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    // Halt freezes everything, even a same-cycle redirect.
                    if (halt_hit) begin
                        state_d = ST_HALT;
                    end else if (redirect || !i_stall) begin
                        imem_re   = 1'b1;
                        out_pc_d  = pc_q;
                        out_npc_d = pc_q + PC_STEP;
                        valid_d   = !redirect;
                        pc_d      = redirect ? redirect_pc : pc_q + PC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            out_pc_q   <= '0;
            out_npc_q  <= PC_STEP;
            valid_q    <= 1'b0;
            load_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_pc_q   <= out_pc_d;
            out_npc_q  <= out_npc_d;
            valid_q    <= valid_d;
            load_cnt_q <= load_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    fetch_imem #(
        .ADDR_W (IMEM_ADDR_W),
        .DATA_W (INST_SIZE)
    ) u_imem (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_we    (imem_we & ~i_reset),
        .i_waddr (load_cnt_q[IMEM_ADDR_W-1:0]),
        .i_wdata ({shift_q, i_load_byte}),
        .i_re    (imem_re),
        .i_raddr (pc_q[IMEM_ADDR_W+1:2]),
        .o_rdata (imem_rdata)
    );

    assign o_pc         = out_pc_q;
    assign o_next_pc    = out_npc_q;
    assign o_instr      = imem_rdata;
    assign o_valid      = valid_q;
    assign o_halt       = (state_q == ST_HALT);
    assign o_load_count = load_cnt_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a spec-level reference model feeds expectation
// queues that a monitor drains against the DUT outputs.
module tb_fetch_unit;

    localparam int          DEPTH = 256;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset = 1'b1, i_load_start = 1'b0, i_load_valid = 1'b0, i_run = 1'b0;
    logic        i_stall = 1'b0, i_branch = 1'b0, i_jal = 1'b0, i_jalr = 1'b0;
    logic [7:0]  i_load_byte = '0;
    logic [31:0] i_branch_addr = '0, i_jump_addr = '0, i_last_reg = '0;
    logic [31:0] o_pc, o_next_pc, o_instr;
    logic        o_valid, o_halt;
    logic [8:0]  o_load_count;
    logic [1:0]  o_state;

    fetch_unit dut (
        .i_clock(clk), .i_reset(i_reset), .i_load_start(i_load_start),
        .i_load_valid(i_load_valid), .i_load_byte(i_load_byte), .i_run(i_run),
        .i_stall(i_stall), .i_branch(i_branch), .i_jal(i_jal), .i_jalr(i_jalr),
        .i_branch_addr(i_branch_addr), .i_jump_addr(i_jump_addr), .i_last_reg(i_last_reg),
        .o_pc(o_pc), .o_next_pc(o_next_pc), .o_instr(o_instr), .o_valid(o_valid),
        .o_halt(o_halt), .o_load_count(o_load_count), .o_state(o_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: spec-level view of what the unit presents after each edge.
    int          m_state = 0;
    bit [31:0]   m_pc = 0, m_opc = 0, m_onpc = 4, m_oinstr = 0, m_shift = 0;
    bit          m_ovalid = 0;
    int          m_cnt = 0, m_bc = 0;
    bit [31:0]   m_mem [DEPTH];

    typedef struct { bit [31:0] pc, npc, instr; } fetch_t;
    typedef struct { bit [1:0] st; bit valid, halt; bit [8:0] cnt; } stat_t;
    fetch_t fq[$];
    stat_t  sq[$];

    task automatic model_step();
        bit [31:0] tgt;
        bit        redir;
        redir = i_jalr || i_jal || i_branch;
        if (i_reset) begin
            m_state = 0; m_pc = 0; m_opc = 0; m_onpc = 4; m_oinstr = 0;
            m_ovalid = 0; m_cnt = 0; m_bc = 0;
        end else if (i_load_start) begin
            m_state = 1; m_cnt = 0; m_bc = 0; m_ovalid = 0;
        end else if (m_state <= 1) begin
            if (i_run) begin
                m_state = 2; m_pc = 0; m_bc = 0; m_ovalid = 0;
            end else if (m_state == 1 && i_load_valid && m_cnt < DEPTH) begin
                m_shift = (m_shift << 8) | 32'(i_load_byte);
                m_bc++;
                if (m_bc == 4) begin
                    m_mem[m_cnt] = m_shift;
                    m_cnt++;
                    m_bc = 0;
                end
            end
        end else if (m_state == 2) begin
            if (m_ovalid && m_oinstr == HALTW) begin
                m_state = 3;
            end else if (redir || !i_stall) begin
                tgt = i_jalr ? i_last_reg : i_jal ? i_jump_addr : i_branch ? i_branch_addr : m_pc + 4;
                m_opc = m_pc;
                m_onpc = m_pc + 4;
                m_oinstr = m_mem[(m_pc >> 2) % DEPTH];
                m_ovalid = !redir;
                m_pc = tgt;
            end
        end
    endtask

    // Inputs are set at a negedge; tick predicts, crosses one posedge, clears inputs.
    task automatic tick();
        stat_t  s;
        fetch_t f;
        model_step();
        s.st = 2'(m_state); s.valid = m_ovalid; s.halt = (m_state == 3); s.cnt = 9'(m_cnt);
        sq.push_back(s);
        if (m_ovalid) begin
            f.pc = m_opc; f.npc = m_onpc; f.instr = m_oinstr;
            fq.push_back(f);
        end
        @(negedge clk);
        i_reset = 0; i_load_start = 0; i_load_valid = 0; i_run = 0;
        i_stall = 0; i_branch = 0; i_jal = 0; i_jalr = 0;
    endtask

    always @(posedge clk) begin
        stat_t  s;
        fetch_t f;
        #1;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("state", 64'(o_state), 64'(s.st));
            chk("valid", 64'(o_valid), 64'(s.valid));
            chk("halt", 64'(o_halt), 64'(s.halt));
            chk("load_count", 64'(o_load_count), 64'(s.cnt));
        end
        if (o_valid === 1'b1) begin
            if (fq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL fetch_extra: valid output pc=%0h with nothing expected", o_pc);
            end else begin
                f = fq.pop_front();
                chk("pc", 64'(o_pc), 64'(f.pc));
                chk("next_pc", 64'(o_next_pc), 64'(f.npc));
                chk("instr", 64'(o_instr), 64'(f.instr));
            end
        end
    end

    task automatic load_word(input bit [31:0] w);
        for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) tick();
            i_load_valid = 1;
            i_load_byte  = w[31-8*b -: 8];
            tick();
        end
    endtask

    function automatic bit [31:0] rand_word();
        bit [31:0] w;
        w = $urandom();
        if (w == HALTW) w = 32'h0;
        return w;
    endfunction

    function automatic bit [31:0] rand_target();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'hFFFF_FFF8;
        if (r == 1) return $urandom();
        return 32'($urandom_range(0, 400)) * 4;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit [31:0] cur_word;
        int        halt_cycles;
        @(negedge clk);
        i_reset = 1; tick();
        chk("reset_next_pc", 64'(o_next_pc), 64'd4);
        chk("reset_state", 64'(o_state), 64'd0);

        // Fill all of memory, then confirm bytes beyond full are ignored.
        i_load_start = 1; tick();
        for (int w = 0; w < DEPTH; w++) load_word(rand_word());
        chk("full_count", 64'(o_load_count), 64'd256);
        load_word(32'hDEAD_BEEF);
        load_word(32'hCAFE_F00D);
        chk("full_no_wrap", 64'(o_load_count), 64'd256);

        // Reset mid-word discards the partial bytes.
        i_load_start = 1; tick();
        i_load_valid = 1; i_load_byte = 8'hAA; tick();
        i_load_valid = 1; i_load_byte = 8'hBB; tick();
        i_reset = 1; tick();
        chk("reset_mid_load_count", 64'(o_load_count), 64'd0);
        i_load_start = 1; tick();
        load_word(32'h1234_5678);
        chk("one_word_count", 64'(o_load_count), 64'd1);
        load_word(rand_word());
        load_word(rand_word());
        chk("three_word_count", 64'(o_load_count), 64'd3);

        // Sequential fetch, stall hold, then a triple redirect.
        i_run = 1; tick();
        tick();
        chk("seq_pc0", 64'(o_pc), 64'h0);
        chk("seq_instr0", 64'(o_instr), 64'h1234_5678);
        tick();
        chk("seq_pc4", 64'(o_pc), 64'h4);
        chk("seq_npc8", 64'(o_next_pc), 64'h8);
        tick();
        chk("seq_pc8", 64'(o_pc), 64'h8);
        for (int k = 0; k < 3; k++) begin
            i_stall = 1; tick();
            chk("stall_hold_pc", 64'(o_pc), 64'h8);
        end
        tick();
        chk("stall_resume_pc", 64'(o_pc), 64'hC);
        i_branch = 1; i_jal = 1; i_jalr = 1;
        i_branch_addr = 32'h10; i_jump_addr = 32'h20; i_last_reg = 32'h30;
        tick();
        chk("redirect_squash", 64'(o_valid), 64'd0);
        tick();
        chk("redirect_pc", 64'(o_pc), 64'h30);
        chk("redirect_valid", 64'(o_valid), 64'd1);

        // Halt on word 2, frozen for ten cycles despite noise, left via load start.
        i_load_start = 1; tick();
        load_word(rand_word());
        load_word(rand_word());
        load_word(HALTW);
        i_run = 1; tick();
        repeat (4) tick();
        for (int k = 0; k < 10; k++) begin
            i_stall = 1'($urandom_range(0, 1));
            i_branch = 1'($urandom_range(0, 1));
            i_run = 1'($urandom_range(0, 1));
            i_branch_addr = rand_target();
            tick();
            chk("halt_flag", 64'(o_halt), 64'd1);
            chk("halt_pc_frozen", 64'(o_pc), 64'h8);
        end
        i_load_start = 1; tick();
        chk("halt_exit_load", 64'(o_state), 64'd1);

        // Randomized traffic.
        cur_word = 0;
        halt_cycles = 0;
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = $urandom_range(0, 99);
            case (m_state)
                0: if (r < 80) i_load_start = 1; else i_run = 1;
                1: begin
                    if (r < 2) i_reset = 1;
                    else if (r < 5) i_load_start = 1;
                    else if (r < 13) i_run = 1;
                    else if ($urandom_range(0, 3) != 0) begin
                        if (m_bc == 0) cur_word = ($urandom_range(0, 9) == 0) ? HALTW : rand_word();
                        i_load_valid = 1;
                        i_load_byte = cur_word[31-8*m_bc -: 8];
                    end
                end
                2: begin
                    if (r < 1) i_reset = 1;
                    else if (r < 2) i_load_start = 1;
                    else begin
                        i_stall  = ($urandom_range(0, 3) == 0);
                        i_branch = ($urandom_range(0, 11) == 0);
                        i_jal    = ($urandom_range(0, 11) == 0);
                        i_jalr   = ($urandom_range(0, 11) == 0);
                        i_run    = ($urandom_range(0, 19) == 0);
                        i_load_valid = ($urandom_range(0, 9) == 0);
                        i_load_byte  = 8'($urandom());
                        i_branch_addr = rand_target();
                        i_jump_addr   = rand_target();
                        i_last_reg    = rand_target();
                    end
                end
                default: begin
                    halt_cycles++;
                    if (r < 5) i_reset = 1;
                    else if (halt_cycles > 4 && r < 40) begin
                        i_load_start = 1;
                        halt_cycles = 0;
                    end else begin
                        i_run = 1'($urandom_range(0, 1));
                        i_stall = 1'($urandom_range(0, 1));
                        i_jal = 1'($urandom_range(0, 1));
                        i_jump_addr = rand_target();
                    end
                end
            endcase
            tick();
        end

        chk("fetch_queue_drained", 64'(fq.size()), 64'd0);
        chk("status_queue_drained", 64'(sq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
